// File: rtl/fetch_unit.sv
// fetch_unit: MIPS instruction-fetch stage owning the PC and the instruction register.
//
// Ports:
//   i_clk           rising-edge clock
//   i_rst_n         asynchronous active-low reset
//   o_imem_req      fetch request, high in FETCH until i_imem_rvalid
//   o_imem_addr     fetch address (= pc)
//   i_imem_rvalid   read data valid, sampled only in FETCH
//   i_imem_rdata    instruction word
//   o_instr_valid   held instruction valid for the execute stage
//   o_instr         held instruction register
//   o_op / o_funct  IR[31:26] / IR[5:0]
//   o_pc            address of the held instruction
//   i_instr_ack     execute stage completed the held instruction
//   i_pcsrc/i_jump  branch-taken / jump decisions, sampled with i_instr_ack
//   o_instr_count   number of acknowledged instructions
//   o_fetch_err     sticky fetch-timeout error
module fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [5:0]  o_op,
  output logic [5:0]  o_funct,
  output logic [31:0] o_pc,
  input  logic        i_instr_ack,
  input  logic        i_pcsrc,
  input  logic        i_jump,
  output logic [31:0] o_instr_count,
  output logic        o_fetch_err
);
  typedef enum logic [1:0] {FETCH, ISSUE, ERROR} state_t;
  localparam logic [31:0] TLIM = 32'(TIMEOUT_CYCLES - 1);
  state_t r_state;
  logic [31:0] r_pc, r_ir, r_wait, r_count;
  logic r_valid, r_err;
  logic [31:0] w_pcplus4, w_boff, w_next_pc;
  logic w_timeout;
  assign w_pcplus4 = r_pc + 32'd4;
  assign w_boff = {{14{r_ir[15]}}, r_ir[15:0], 2'b00};
  assign w_next_pc = i_jump ? {w_pcplus4[31:28], r_ir[25:0], 2'b00}
                   : i_pcsrc ? w_pcplus4 + w_boff : w_pcplus4;
  // The wait cycle that would bring the counter to TIMEOUT_CYCLES ends the fetch.
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_wait == TLIM);
  // Request is gated by reset so it is low while reset is asserted.
  assign o_imem_req = i_rst_n & (r_state == FETCH);
  assign o_imem_addr = r_pc;
  assign o_instr_valid = r_valid;
  assign o_instr = r_ir;
  assign o_op = r_ir[31:26];
  assign o_funct = r_ir[5:0];
  assign o_pc = r_pc;
  assign o_instr_count = r_count;
  assign o_fetch_err = r_err;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= FETCH;
      r_pc <= RESET_PC;
      r_ir <= '0;
      r_wait <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (i_imem_rvalid) begin
            r_ir <= i_imem_rdata;
            r_valid <= 1'b1;
            r_state <= ISSUE;
          end else if (w_timeout) begin
            r_err <= 1'b1;
            r_state <= ERROR;
          end else begin
            r_wait <= r_wait + 32'd1;
          end
        end
        ISSUE: begin
          if (i_instr_ack) begin
            r_pc <= w_next_pc;
            r_count <= r_count + 32'd1;
            r_wait <= '0;
            r_valid <= 1'b0;
            r_state <= FETCH;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plus randomized check of fetch_unit against a behavioural PC/IR model.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst_n;
  logic imem_req, imem_rvalid, instr_valid, instr_ack, pcsrc, jump, fetch_err;
  logic [31:0] imem_addr, imem_rdata, instr, pc, instr_count;
  logic [5:0] op, funct;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_pc, m_ir, m_count;

  fetch_unit #(.RESET_PC(32'h0), .TIMEOUT_CYCLES(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_rvalid(imem_rvalid), .i_imem_rdata(imem_rdata),
    .o_instr_valid(instr_valid), .o_instr(instr), .o_op(op), .o_funct(funct), .o_pc(pc),
    .i_instr_ack(instr_ack), .i_pcsrc(pcsrc), .i_jump(jump),
    .o_instr_count(instr_count), .o_fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] ir,
                                           input logic br, input logic j);
    int imm;
    imm = int'($signed(ir[15:0]));
    if (j) return ((p + 32'd4) & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) << 2);
    if (br) return p + 32'd4 + 32'(imm * 4);
    return p + 32'd4;
  endfunction

  task automatic fetch(input logic [31:0] word, input int lat);
    for (int i = 0; i < lat; i++) begin
      chk("wait_req", imem_req, 1'b1);
      chk("wait_addr", imem_addr, m_pc);
      chk("wait_valid", instr_valid, 1'b0);
      imem_rvalid = 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
    end
    chk("fetch_req", imem_req, 1'b1);
    chk("fetch_addr", imem_addr, m_pc);
    imem_rvalid = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata = $urandom;
    m_ir = word;
    chk("issue_valid", instr_valid, 1'b1);
    chk("issue_req", imem_req, 1'b0);
    chk("issue_instr", instr, word);
    chk("issue_op", {26'b0, op}, {26'b0, word[31:26]});
    chk("issue_funct", {26'b0, funct}, {26'b0, word[5:0]});
    chk("issue_pc", pc, m_pc);
  endtask

  task automatic issue(input int hold, input logic br, input logic j);
    for (int i = 0; i < hold; i++) begin
      instr_ack = 1'b0;
      pcsrc = 1'($urandom);
      jump = 1'($urandom);
      imem_rvalid = 1'($urandom);
      imem_rdata = $urandom;
      @(negedge clk);
      chk("hold_valid", instr_valid, 1'b1);
      chk("hold_instr", instr, m_ir);
      chk("hold_pc", pc, m_pc);
      chk("hold_req", imem_req, 1'b0);
    end
    imem_rvalid = 1'b0;
    instr_ack = 1'b1;
    pcsrc = br;
    jump = j;
    @(negedge clk);
    instr_ack = 1'b0;
    pcsrc = 1'b0;
    jump = 1'b0;
    m_pc = ref_next(m_pc, m_ir, br, j);
    m_count = m_count + 32'd1;
    chk("ack_count", instr_count, m_count);
    chk("ack_req", imem_req, 1'b1);
    chk("ack_addr", imem_addr, m_pc);
    chk("ack_valid", instr_valid, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    instr_ack = 1'b0;
    pcsrc = 1'b0;
    jump = 1'b0;
    m_pc = 32'h0;
    m_count = 32'h0;
    m_ir = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_count", instr_count, 32'h0);
    chk("rst_err", fetch_err, 1'b0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rel_req", imem_req, 1'b1);
    chk("rel_addr", imem_addr, 32'h0);
    @(negedge clk);
    chk("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 32'h0);
    chk("first_valid", instr_valid, 1'b0);
    chk("first_count", instr_count, 32'h0);
    fetch(32'h0022_1820, 0);
    issue(0, 1'b0, 1'b0);
    chk("seq_addr", imem_addr, 32'h4);
    fetch(32'h0000_0020, 0);
    issue(0, 1'b0, 1'b0);
    fetch(32'h1000_FFFE, 0);
    issue(0, 1'b1, 1'b0);
    chk("beq_taken", imem_addr, 32'h4);
    fetch(32'h0000_0020, 0);
    issue(0, 1'b0, 1'b0);
    fetch(32'h1000_FFFE, 0);
    issue(0, 1'b0, 1'b0);
    chk("beq_not_taken", imem_addr, 32'hC);
    fetch(32'h0000_0020, 0);
    issue(0, 1'b0, 1'b0);
    fetch(32'h0800_0040, 0);
    issue(0, 1'b1, 1'b1);
    chk("jump_prio", imem_addr, 32'h100);
    fetch($urandom, 3);
    issue(5, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      fetch($urandom, int'($urandom_range(0, 3)));
      issue(int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 3; i++) begin
      imem_rvalid = 1'b0;
      @(negedge clk);
      chk("to_wait_req", imem_req, 1'b1);
      chk("to_wait_err", fetch_err, 1'b0);
    end
    @(negedge clk);
    chk("to_err", fetch_err, 1'b1);
    chk("to_req", imem_req, 1'b0);
    chk("to_valid", instr_valid, 1'b0);
    imem_rvalid = 1'b1;
    instr_ack = 1'b1;
    imem_rdata = $urandom;
    repeat (3) @(negedge clk);
    imem_rvalid = 1'b0;
    instr_ack = 1'b0;
    chk("err_sticky", fetch_err, 1'b1);
    chk("err_req", imem_req, 1'b0);
    chk("err_valid", instr_valid, 1'b0);
    chk("err_count", instr_count, m_count);
    rst_n = 1'b0;
    #1;
    chk("rst_err_drop", fetch_err, 1'b0);
    chk("rst_err_req", imem_req, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = 32'h0;
    m_count = 32'h0;
    #1;
    chk("rel2_addr", imem_addr, 32'h0);
    fetch(32'h0000_0020, 1);
    issue(0, 1'b0, 1'b0);
    fetch($urandom, 2);
    rst_n = 1'b0;
    #1;
    chk("midissue_valid", instr_valid, 1'b0);
    chk("midissue_count", instr_count, 32'h0);
    chk("midissue_pc", pc, 32'h0);
    chk("midissue_req", imem_req, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = 32'h0;
    m_count = 32'h0;
    #1;
    chk("rel3_req", imem_req, 1'b1);
    chk("rel3_addr", imem_addr, 32'h0);
    fetch(32'h0022_1820, 0);
    issue(1, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage for the MIPS core: owns the PC, fetches one instruction at a time from instruction memory over a req/rvalid handshake, and holds it in an instruction register. It presents op/funct/instr to the control/decode stage. It computes the next PC (PC+4, branch target or jump target) from the pcsrc/jump decisions returned when the instruction completes.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; first fetch address.
TIMEOUT_CYCLES, 255, max cycles imem_req may stay high without imem_rvalid before error; 0 disables timeout.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
imem_req  out  1  fetch request; held high until imem_rvalid.
imem_addr  out  32  fetch address (= pc); stable while imem_req high.
imem_rvalid  in  1  read data valid; sampled only in FETCH.
imem_rdata  in  32  instruction word.
instr_valid  out  1  instr/op/funct valid for the execute stage.
instr  out  32  held instruction register (IR).
op  out  6  IR[31:26].
funct  out  6  IR[5:0].
pc  out  32  address of the held instruction.
instr_ack  in  1  execute stage has completed the held instruction; sampled only when instr_valid.
pcsrc  in  1  branch taken; sampled with instr_ack.
jump  in  1  jump; sampled with instr_ack.
instr_count  out  32  number of acknowledged instructions.
fetch_err  out  1  sticky fetch-timeout error.

Behaviour:
- Reset (rst_n low, async): pc=RESET_PC, IR=0, state=FETCH, wait counter=0, instr_count=0, fetch_err=0. All outputs take their reset values immediately. imem_req=0 while rst_n is low.
- Outputs are registered state, except that imem_req/imem_addr decode directly from state/pc.
- State FETCH: imem_req=1, imem_addr=pc, instr_valid=0.
  - If imem_rvalid=1 (including the first req cycle, for a zero-latency memory): IR<=imem_rdata, go to ISSUE.
  - Otherwise wait counter increments.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES with no rvalid: go to ERROR.
  - The counter clears on every entry to FETCH.
- State ISSUE: instr_valid=1, imem_req=0; IR, op, funct and pc are held stable.
  - On instr_ack=1: pc<=next_pc, instr_count<=instr_count+1 (wraps modulo 2^32), go to FETCH.
  - An instruction is therefore valid at the earliest 1 cycle after rvalid, and the next request is issued the cycle after ack.
- State ERROR: imem_req=0, instr_valid=0, fetch_err=1. Exit only via reset. imem_rvalid and instr_ack are ignored.
- next_pc, with pcplus4=pc+4 (32-bit, wraps):
  - jump=1: {pcplus4[31:28], IR[25:0], 2'b00}. Jump has priority over pcsrc.
  - else pcsrc=1: pcplus4 + (signext(IR[15:0]) << 2), 32-bit wrap.
  - else: pcplus4.
  - X on pcsrc/jump at ack is treated as not-taken only if the value resolves to 0. The bench must drive known values.
- imem_rvalid in ISSUE/ERROR, and instr_ack outside ISSUE: ignored, no state change.
- Async reset mid-FETCH or mid-ISSUE aborts the access. The first request after release is to RESET_PC, and the pending instruction is discarded.

Test Plan:
- Reset/first fetch: hold rst_n=0, release -> next edge shows imem_req=1, imem_addr=0x00000000, instr_valid=0, instr_count=0.
- Sequential: zero-latency memory, 0x0 holds 0x00221820 -> instr_valid=1 one cycle later with op=0x00, funct=0x20; ack with pcsrc=0, jump=0 -> imem_addr=0x00000004, instr_count=1.
- Branch: pc=0x8, instr 0x1000FFFE (beq, imm=-2), ack with pcsrc=1 -> next imem_addr=0x00000004. Same instr with pcsrc=0 -> 0x0000000C.
- Jump priority: pc=0x10, instr 0x08000040, ack with jump=1 and pcsrc=1 -> next imem_addr=0x00000100.
- Latency/stall: rvalid returned 3 cycles after req -> imem_req and imem_addr stable for all 3 cycles, instr_valid 1 cycle after rvalid. Hold instr_ack=0 for 5 cycles -> IR/pc unchanged, no new req.
- Timeout and reset: TIMEOUT_CYCLES=4, never assert rvalid -> fetch_err=1 and imem_req=0 after 4 wait cycles, rvalid then ignored. Pulse rst_n low mid-ISSUE -> instr_valid and fetch_err drop immediately, next fetch at RESET_PC.
